// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// The request struct is sized by the package widths, which the top uses as its parameter defaults.
package dmem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    localparam logic MW_BYTE = 1'b0;
    localparam logic MW_WORD = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic                  width;
    } req_t;

    // Big-endian lane pick: offset 0 is the most significant byte.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] off);
        logic [7:0] lane;
        case (off)
            2'd0:    lane = word[31:24];
            2'd1:    lane = word[23:16];
            2'd2:    lane = word[15:8];
            default: lane = word[7:0];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant plus a last-served pointer.
// With both requests pending, the port not served last wins; the pointer resets to 1.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       last
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11)
            gnt = last ? 2'b01 : 2'b10;
        else
            gnt = req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last <= 1'b1;
        else if (advance)
            last <= gnt[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between port 0 (CPU) and port 1 (debug/DMA), one access in flight.
// Build option DMEM_ARB_BYTE_LOAD_EN: byte loads return the addressed big-endian lane, zero-extended.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int WORDS  = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_width,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_width,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_width,
    input  logic [DATA_W-1:0] mem_rd,

    output logic [1:0]        state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // valid must not depend on ready; ready is only offered in IDLE to the arbitration winner.

    localparam logic [ADDR_W-3:0] WORDS_W = (ADDR_W-2)'(WORDS);

    state_t            state, state_nxt;
    req_t              req_q;
    logic              gport;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [1:0]        gnt;
    logic              last;
    logic              accept;
    logic              rsp_fire;
    logic              in_range;
    logic [DATA_W-1:0] load_data;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({req1_valid, req0_valid}),
        .advance (accept),
        .gnt     (gnt),
        .last    (last)
    );

    assign accept     = (state == IDLE) && (gnt != 2'b00);
    assign req0_ready = (state == IDLE) && gnt[0];
    assign req1_ready = (state == IDLE) && gnt[1];
    assign rsp_fire   = (state == RESP) && (gport ? rsp1_ready : rsp0_ready);
    assign in_range   = (req_q.addr[ADDR_W-1:2] < WORDS_W);
    assign state_dbg  = state;

`ifdef DMEM_ARB_BYTE_LOAD_EN
    assign load_data = (req_q.width == MW_BYTE)
                     ? DATA_W'(byte_lane(mem_rd[31:0], req_q.addr[1:0]))
                     : mem_rd;
`else
    assign load_data = mem_rd;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = ACCESS;
            ACCESS:                state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;
        mem_width = MW_WORD;
        if (state == ACCESS) begin
            mem_we    = req_q.we && in_range;
            mem_a     = req_q.addr;
            mem_wd    = req_q.wdata;
            mem_width = req_q.width;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            req_q   <= '0;
            gport   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                gport <= gnt[1];
                req_q <= gnt[1] ? '{req1_we, req1_addr, req1_wdata, req1_width}
                                : '{req0_we, req0_addr, req0_wdata, req0_width};
            end
            if (state == ACCESS) begin
                // Stores and out-of-range accesses return zero data.
                rdata_q <= (!req_q.we && in_range) ? load_data : '0;
                err_q   <= !in_range;
            end else if (rsp_fire) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign rsp0_valid = (state == RESP) && !gport;
    assign rsp1_valid = (state == RESP) &&  gport;
    assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
    assign rsp1_rdata = rsp1_valid ? rdata_q : '0;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;

    logic unused_last;
    assign unused_last = last;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural big-endian dmem on the mem pins.
// Honours DMEM_ARB_BYTE_LOAD_EN for the byte-load expectation.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_we, req0_width;
    logic [31:0] req0_addr, req0_wdata;
    logic        rsp0_valid, rsp0_ready, rsp0_err;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we, req1_width;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp1_valid, rsp1_ready, rsp1_err;
    logic [31:0] rsp1_rdata;
    logic        mem_we, mem_width;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [1:0]  state_dbg;

    int vectors     = 0;
    int miscompares = 0;
    int we_cycles   = 0;

    logic [31:0] mem [64];

    dmem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_width (req0_width),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_width (req1_width),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_width  (mem_width),
        .mem_rd     (mem_rd),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dmem model ----------------
    assign mem_rd = (mem_a[31:8] != 24'd0) ? 32'hBAD0_BAD0 : mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            we_cycles <= we_cycles + 1;
            if (mem_a[31:8] == 24'd0) begin
                if (mem_width)
                    mem[mem_a[7:2]] <= mem_wd;
                else
                    case (mem_a[1:0])
                        2'd0: mem[mem_a[7:2]][31:24] <= mem_wd[7:0];
                        2'd1: mem[mem_a[7:2]][23:16] <= mem_wd[7:0];
                        2'd2: mem[mem_a[7:2]][15:8]  <= mem_wd[7:0];
                        default: mem[mem_a[7:2]][7:0] <= mem_wd[7:0];
                    endcase
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Present a request and return at the negedge after the accepting edge (ACCESS cycle).
    task automatic issue(input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic width);
        bit ok;
        ok = 1'b0;
        if (port == 0) begin
            req0_we = we; req0_addr = addr; req0_wdata = wdata; req0_width = width; req0_valid = 1'b1;
        end else begin
            req1_we = we; req1_addr = addr; req1_wdata = wdata; req1_width = width; req1_valid = 1'b1;
        end
        #1;
        for (int i = 0; i < 20; i++) begin
            if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL issue_timeout port=%0d addr=%h: ready never seen within 20 cycles", port, addr);
        end
        @(posedge clk);
        #1;
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic consume(input int port);
        if (port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        vectors++; if (state_dbg !== IDLE) begin miscompares++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
        vectors++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b%b exp=00", rsp1_valid, rsp0_valid); end
        vectors++; if (mem_we !== 1'b0 || mem_width !== 1'b1 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin miscompares++; $display("FAIL reset_mem got we=%b w=%b a=%h wd=%h exp we=0 w=1 a=0 wd=0", mem_we, mem_width, mem_a, mem_wd); end
        vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
    endtask

    task automatic test_word_store_load();
        int n;
        n = we_cycles;
        issue(0, 1'b1, 32'h8, 32'hDEAD_BEEF, MW_WORD);
        vectors++; if (mem_we !== 1'b1 || mem_a !== 32'h8 || mem_wd !== 32'hDEAD_BEEF || mem_width !== 1'b1) begin miscompares++; $display("FAIL store_access got we=%b a=%h wd=%h w=%b exp we=1 a=8 wd=deadbeef w=1", mem_we, mem_a, mem_wd, mem_width); end
        vectors++; if (rsp0_valid !== 1'b0) begin miscompares++; $display("FAIL store_early_rsp got=%b exp=0", rsp0_valid); end
        @(negedge clk);
        vectors++; if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b0 || rsp0_rdata !== 32'h0) begin miscompares++; $display("FAIL store_rsp got v=%b err=%b d=%h exp v=1 err=0 d=0", rsp0_valid, rsp0_err, rsp0_rdata); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL store_we_in_resp got=%b exp=0", mem_we); end
        vectors++; if (we_cycles - n !== 1) begin miscompares++; $display("FAIL store_we_cycles got=%0d exp=1", we_cycles - n); end
        vectors++; if (mem[2] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL store_mem got=%h exp=deadbeef", mem[2]); end
        consume(0);
        issue(0, 1'b0, 32'h8, 32'h0, MW_WORD);
        vectors++; if (rsp0_valid !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL load_access got v=%b we=%b exp v=0 we=0", rsp0_valid, mem_we); end
        @(negedge clk);
        vectors++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEAD_BEEF || rsp0_err !== 1'b0) begin miscompares++; $display("FAIL load_rsp got v=%b d=%h err=%b exp v=1 d=deadbeef err=0", rsp0_valid, rsp0_rdata, rsp0_err); end
        consume(0);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq;
        int         got;
        bit         ok;
        exp_seq = 4'b1010;  // bit t = expected granted port of transaction t
        do_reset();
        req0_we = 1'b0; req0_addr = 32'h8;  req0_wdata = 32'h0; req0_width = MW_WORD;
        req1_we = 1'b0; req1_addr = 32'h10; req1_wdata = 32'h0; req1_width = MW_WORD;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        for (int t = 0; t < 4; t++) begin
            ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (req0_ready || req1_ready) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            got = req1_ready ? 1 : 0;
            vectors++;
            if (!ok || (req0_ready && req1_ready) || got != int'(exp_seq[t])) begin
                miscompares++;
                $display("FAIL rr_grant t=%0d got r0=%b r1=%b exp port=%0d", t, req0_ready, req1_ready, exp_seq[t]);
            end
            @(posedge clk); #1;
            @(negedge clk);
            vectors++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin miscompares++; $display("FAIL rr_access_rsp t=%0d got=%b%b exp=00", t, rsp1_valid, rsp0_valid); end
            @(negedge clk);
            vectors++;
            if ((exp_seq[t] == 1'b0 && (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0)) ||
                (exp_seq[t] == 1'b1 && (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0))) begin
                miscompares++;
                $display("FAIL rr_rsp_owner t=%0d got v1v0=%b%b exp port=%0d only", t, rsp1_valid, rsp0_valid, exp_seq[t]);
            end
            @(posedge clk); #1;
            @(negedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_byte_lanes();
        logic [31:0] exp_byte_load;
`ifdef DMEM_ARB_BYTE_LOAD_EN
        exp_byte_load = 32'h0000_00AA;
`else
        exp_byte_load = 32'h1122_AA44;
`endif
        issue(0, 1'b1, 32'h10, 32'h1122_3344, MW_WORD);
        @(negedge clk); consume(0);
        issue(0, 1'b1, 32'h12, 32'h0000_00AA, MW_BYTE);
        vectors++; if (mem_width !== 1'b0 || mem_a !== 32'h12 || mem_we !== 1'b1) begin miscompares++; $display("FAIL byte_store_pins got w=%b a=%h we=%b exp w=0 a=12 we=1", mem_width, mem_a, mem_we); end
        @(negedge clk); consume(0);
        issue(0, 1'b0, 32'h10, 32'h0, MW_WORD);
        @(negedge clk);
        vectors++; if (rsp0_rdata !== 32'h1122_AA44) begin miscompares++; $display("FAIL byte_word_load got=%h exp=1122aa44", rsp0_rdata); end
        consume(0);
        issue(0, 1'b0, 32'h12, 32'h0, MW_BYTE);
        @(negedge clk);
        vectors++; if (rsp0_rdata !== exp_byte_load) begin miscompares++; $display("FAIL byte_load got=%h exp=%h", rsp0_rdata, exp_byte_load); end
        consume(0);
    endtask

    task automatic test_range();
        int n;
        n = we_cycles;
        issue(0, 1'b1, 32'h100, 32'hCAFE_F00D, MW_WORD);
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL oor_store_we got=%b exp=0", mem_we); end
        @(negedge clk);
        vectors++; if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b1 || rsp0_rdata !== 32'h0) begin miscompares++; $display("FAIL oor_store_rsp got v=%b err=%b d=%h exp v=1 err=1 d=0", rsp0_valid, rsp0_err, rsp0_rdata); end
        consume(0);
        vectors++; if (we_cycles !== n || mem[0] !== 32'h0) begin miscompares++; $display("FAIL oor_no_write got cycles=%0d mem0=%h exp cycles=%0d mem0=0", we_cycles, mem[0], n); end
        issue(1, 1'b0, 32'h100, 32'h0, MW_WORD);
        @(negedge clk);
        vectors++; if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b1 || rsp1_rdata !== 32'h0 || rsp0_valid !== 1'b0) begin miscompares++; $display("FAIL oor_load_rsp got v1=%b err=%b d=%h v0=%b exp v1=1 err=1 d=0 v0=0", rsp1_valid, rsp1_err, rsp1_rdata, rsp0_valid); end
        consume(1);
        issue(0, 1'b0, 32'hFC, 32'h0, MW_WORD);
        @(negedge clk);
        vectors++; if (rsp0_err !== 1'b0 || rsp0_rdata !== 32'h0) begin miscompares++; $display("FAIL last_word_rsp got err=%b d=%h exp err=0 d=0", rsp0_err, rsp0_rdata); end
        consume(0);
    endtask

    task automatic test_backpressure();
        bit stable;
        stable = 1'b1;
        issue(0, 1'b0, 32'h8, 32'h0, MW_WORD);
        req1_we = 1'b0; req1_addr = 32'h10; req1_wdata = 32'h0; req1_width = MW_WORD; req1_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEAD_BEEF || req1_ready !== 1'b0 || rsp1_valid !== 1'b0)
                stable = 1'b0;
            @(negedge clk);
        end
        vectors++; if (!stable) begin miscompares++; $display("FAIL hold_stable got v0=%b d=%h r1=%b exp v0=1 d=deadbeef r1=0", rsp0_valid, rsp0_rdata, req1_ready); end
        consume(0);
        vectors++; if (req1_ready !== 1'b1 || state_dbg !== IDLE) begin miscompares++; $display("FAIL hold_next_accept got r1=%b st=%0d exp r1=1 st=0", req1_ready, state_dbg); end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h1122_AA44) begin miscompares++; $display("FAIL hold_req1_rsp got v=%b d=%h exp v=1 d=1122aa44", rsp1_valid, rsp1_rdata); end
        consume(1);
    endtask

    task automatic test_reset_mid_access();
        issue(0, 1'b1, 32'h20, 32'h5555_5555, MW_WORD);
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL rst_pre_we got=%b exp=1", mem_we); end
        #1 reset = 1'b1;
        #1;
        vectors++; if (mem_we !== 1'b0 || state_dbg !== IDLE || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin miscompares++; $display("FAIL rst_async got we=%b st=%0d v=%b%b exp we=0 st=0 v=00", mem_we, state_dbg, rsp1_valid, rsp0_valid); end
        @(posedge clk); #1;
        vectors++; if (mem[8] !== 32'h0) begin miscompares++; $display("FAIL rst_no_write got=%h exp=0", mem[8]); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(0, 1'b0, 32'h20, 32'h0, MW_WORD);
        @(negedge clk);
        vectors++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_reload got v=%b d=%h exp v=1 d=0", rsp0_valid, rsp0_rdata); end
        consume(0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        reset = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0; req0_width = 1'b1;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0; req1_width = 1'b1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_word_store_load();
        test_round_robin();
        test_byte_lanes();
        test_range();
        test_backpressure();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
